// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: FSM states, address decode and frame layout.
package icache_pkg;
  localparam int WORD_W    = 32;
  localparam int NSETS_DEF = 16;
  localparam int IDX_W_DEF = $clog2(NSETS_DEF);
  localparam int TAG_W_DEF = WORD_W - IDX_W_DEF - 2;

  typedef enum logic {IDLE, FETCH} icache_state_t;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic [IDX_W_DEF-1:0] idx;
    logic [1:0]           bytoff;
  } icachef_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [WORD_W-1:0]    data;
  } icache_frame_t;
endpackage

// File: rtl/icache_perf_ctr.sv
// Saturating 32-bit event counter; counts on the edge after inc, holds at all-ones, no backpressure.
module icache_perf_ctr
  import icache_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              inc,
  output logic [WORD_W-1:0] count
);
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 32'd1;
  end
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache: combinational hit, blocking fill (miss = mem wait + 2 cycles), memory stalls via iwait.
// Optional hit/miss counters under ICACHE_PERF_EN.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NSETS = NSETS_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
);
  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state;
  logic              drop;
  logic [WORD_W-1:0] maddr;
  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tags  [NSETS];
  logic [WORD_W-1:0] datas [NSETS];

  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic             probe_hit, miss, fill_done;
  logic             unused_boff;

  assign req_tag     = imemaddr[WORD_W-1:IDX_W+2];
  assign req_idx     = imemaddr[IDX_W+1:2];
  assign fill_tag    = maddr[WORD_W-1:IDX_W+2];
  assign fill_idx    = maddr[IDX_W+1:2];
  assign unused_boff = ^imemaddr[1:0];

  assign probe_hit = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
  assign ihit      = (state == IDLE) && !flush && probe_hit;
  assign miss      = (state == IDLE) && imemREN && !probe_hit && !flush;
  assign fill_done = (state == FETCH) && !iwait;
  assign imemload  = ihit ? datas[req_idx] : '0;

  assign iREN  = (state == FETCH);
  assign iaddr = maddr;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      drop  <= 1'b0;
      maddr <= '0;
      valid <= '0;
    end else begin
      if (flush)
        valid <= '0;
      case (state)
        IDLE: begin
          if (miss) begin
            maddr <= {imemaddr[WORD_W-1:2], 2'b00};
            state <= FETCH;
          end
        end
        FETCH: begin
          // A flush seen anywhere during the fill poisons the returning word.
          if (!iwait) begin
            valid[fill_idx] <= !drop && !flush;
            drop            <= 1'b0;
            state           <= IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx]  <= fill_tag;
      datas[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_PERF_EN
  icache_perf_ctr u_hit_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (ihit),
    .count (hit_count)
  );
  icache_perf_ctr u_miss_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (miss),
    .count (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_icache_dm;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = '0;
  logic [31:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  icache_dm dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .flush      (flush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] ev);
    n_cmp++;
    if (obs !== ev) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, ev);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] a, input logic fl,
                       input logic wt, input logic [31:0] ld);
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = a;
    flush    = fl;
    iwait    = wt;
    iload    = ld;
    #1;
  endtask

  // Miss probe, nw busy cycles, data return, then the re-probe that must hit.
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int nw);
    drive(1'b1, a, 1'b0, 1'b1, 32'h0);
    chk("fill_miss_ihit", ihit, 1'b0);
    chk("fill_miss_iren", iREN, 1'b0);
    for (int i = 0; i < nw; i++) begin
      drive(1'b1, a, 1'b0, 1'b1, 32'h0);
      chk("fill_wait_iren", iREN, 1'b1);
      chk("fill_wait_iaddr", iaddr, a);
      chk("fill_wait_ihit", ihit, 1'b0);
    end
    drive(1'b1, a, 1'b0, 1'b0, d);
    chk("fill_ret_iren", iREN, 1'b1);
    chk("fill_ret_iaddr", iaddr, a);
    drive(1'b1, a, 1'b0, 1'b1, 32'h0);
    chk("fill_reprobe_ihit", ihit, 1'b1);
    chk("fill_reprobe_data", imemload, d);
    chk("fill_reprobe_iren", iREN, 1'b0);
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: stimulus did not complete within the wait limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #12;
    chk("rst_ihit", ihit, 1'b0);
    chk("rst_iren", iREN, 1'b0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_misses", miss_count, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // Cold miss with three busy cycles.
    fill(32'h0000_0040, 32'h2001_0005, 3);
    chk("cold_misses", miss_count, PERF ? 32'd1 : 32'd0);

    // Hit streak.
    fill(32'h0000_0044, 32'h1111_1111, 0);
    fill(32'h0000_0048, 32'h2222_2222, 1);
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    chk("streak40_ihit", ihit, 1'b1);
    chk("streak40_data", imemload, 32'h2001_0005);
    drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    chk("streak44_data", imemload, 32'h1111_1111);
    chk("streak44_iren", iREN, 1'b0);
    drive(1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
    chk("streak48_data", imemload, 32'h2222_2222);
    drive(1'b0, 32'h40, 1'b0, 1'b1, 32'h0);
    chk("noren_ihit", ihit, 1'b0);
    chk("streak_hits", hit_count, PERF ? 32'd6 : 32'd0);
    chk("streak_misses", miss_count, PERF ? 32'd3 : 32'd0);

    // Conflict eviction: 0x80 shares index 0 with 0x40.
    fill(32'h0000_0080, 32'h3333_3333, 0);
    fill(32'h0000_0040, 32'h2001_0005, 0);
    drive(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    chk("evict_other_idx_hit", ihit, 1'b1);

    // Redirect mid-fill: the fill still lands at 0x100.
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    chk("redir_miss", ihit, 1'b0);
    drive(1'b1, 32'h208, 1'b0, 1'b1, 32'h0);
    chk("redir_iaddr", iaddr, 32'h100);
    drive(1'b0, 32'h208, 1'b0, 1'b0, 32'hAAAA_0100);
    chk("redir_iren_held", iREN, 1'b1);
    chk("redir_iaddr_held", iaddr, 32'h100);
    fill(32'h0000_0208, 32'hBBBB_0208, 0);
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    chk("redir_orig_hit", ihit, 1'b1);
    chk("redir_orig_data", imemload, 32'hAAAA_0100);

    // Flush while the memory is busy.
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
    chk("fl_miss", ihit, 1'b0);
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h0);
    chk("fl_iren", iREN, 1'b1);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h5555_5555);
    chk("fl_ret_iren", iREN, 1'b1);
    fill(32'h0000_0010, 32'h5555_5555, 0);
    fill(32'h0000_0044, 32'h1111_1111, 0);
    fill(32'h0000_0100, 32'hAAAA_0100, 0);

    // Flush coincident with data return.
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h6666_6666);
    chk("flret_iren", iREN, 1'b1);
    fill(32'h0000_0020, 32'h6666_6666, 0);

    // Flush in IDLE suppresses a hit and does not start a fill.
    drive(1'b1, 32'h20, 1'b1, 1'b1, 32'h0);
    chk("flidle_ihit", ihit, 1'b0);
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
    chk("flidle_no_fetch", iREN, 1'b0);
    chk("flidle_now_miss", ihit, 1'b0);
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h6666_6666);
    chk("flidle_refill_iren", iREN, 1'b1);
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
    chk("flidle_refill_hit", ihit, 1'b1);

    // Reset mid-fill.
    drive(1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
    chk("pre_rst_hits", hit_count, PERF ? 32'd16 : 32'd0);
    chk("pre_rst_misses", miss_count, PERF ? 32'd14 : 32'd0);
    chk("pre_rst_miss48", ihit, 1'b0);
    drive(1'b1, 32'h48, 1'b0, 1'b1, 32'h0);
    chk("pre_rst_iren", iREN, 1'b1);
    nRST = 1'b0;
    #1;
    chk("rst_async_iren", iREN, 1'b0);
    chk("rst_async_iaddr", iaddr, 32'h0);
    chk("rst_async_hits", hit_count, 32'h0);
    drive(1'b0, 32'h20, 1'b0, 1'b0, 32'h7777_7777);
    nRST = 1'b1;
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
    chk("post_rst_iren", iREN, 1'b0);
    chk("post_rst_miss20", ihit, 1'b0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
